// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the arbiter and a UART_TX serializer.
// With UART_ARB_OVF_EN defined, the bundle also carries the sticky drop flags and their clear.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   i_Req_DV;
  logic [NUM_REQ*8-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   o_Req_Full;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Done;
  logic [1:0]           o_Grant_ID;
  logic                 o_Busy;
`ifdef UART_ARB_OVF_EN
  logic [NUM_REQ-1:0]   o_Overflow;
  logic                 i_Ovf_Clr;
`endif

  modport slave (
    input  i_Req_DV, i_Req_Byte, i_TX_Done,
`ifdef UART_ARB_OVF_EN
    input  i_Ovf_Clr,
    output o_Overflow,
`endif
    output o_Req_Full, o_TX_DV, o_TX_Byte, o_Grant_ID, o_Busy
  );

  modport master (
    output i_Req_DV, i_Req_Byte, i_TX_Done,
`ifdef UART_ARB_OVF_EN
    output i_Ovf_Clr,
    input  o_Overflow,
`endif
    input  o_Req_Full, o_TX_DV, o_TX_Byte, o_Grant_ID, o_Busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ single-byte holding registers share one UART_TX.
// Define UART_ARB_OVF_EN to add the sticky per-requester overflow flags for dropped bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

  state_t             state;
  logic [7:0]         hold_byte [NUM_REQ];
  logic [NUM_REQ-1:0] req_full;
  logic [NUM_REQ-1:0] clear_vec;
  logic [NUM_REQ-1:0] load_vec;
  logic               grant_valid;
  logic               grant_fire;
  logic [1:0]         grant_idx;
  logic [7:0]         grant_byte;
  logic [1:0]         last_grant;
  logic               tx_dv;
  logic [7:0]         tx_byte;
  logic               busy;
  int                 search_idx;

  // Walk outward from the requester after the last grant; nearest full one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant;
    grant_byte  = 8'h00;
    search_idx  = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      search_idx = (int'(last_grant) + off) % NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (k == search_idx && req_full[k]) begin
          grant_valid = 1'b1;
          grant_idx   = 2'(k);
          grant_byte  = hold_byte[k];
        end
      end
    end
  end

  assign grant_fire = (state == IDLE) && grant_valid;

  always_comb begin
    clear_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      clear_vec[k] = grant_fire && (grant_idx == 2'(k));
    end
  end

  // A register being emptied by this grant can accept a new byte on the same edge.
  assign load_vec = bus.i_Req_DV & (~req_full | clear_vec);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      req_full <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        hold_byte[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (load_vec[k]) begin
          hold_byte[k] <= bus.i_Req_Byte[8*k +: 8];
          req_full[k]  <= 1'b1;
        end else if (clear_vec[k]) begin
          req_full[k]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= IDLE;
      tx_dv      <= 1'b0;
      tx_byte    <= 8'h00;
      last_grant <= 2'(NUM_REQ - 1);
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_fire) begin
            tx_byte    <= grant_byte;
            last_grant <= grant_idx;
            tx_dv      <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          tx_dv <= 1'b0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.i_TX_Done) begin
            state <= GAP;
          end
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          tx_dv <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_ARB_OVF_EN
  logic [NUM_REQ-1:0] drop_vec;
  logic [NUM_REQ-1:0] overflow;

  assign drop_vec = bus.i_Req_DV & req_full & ~clear_vec;

  // Clear first, then OR in this cycle's drops so a coincident drop survives.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      overflow <= '0;
    end else begin
      overflow <= (bus.i_Ovf_Clr ? '0 : overflow) | drop_vec;
    end
  end

  assign bus.o_Overflow = overflow;
`endif

  assign bus.o_Req_Full = req_full;
  assign bus.o_TX_DV    = tx_dv;
  assign bus.o_TX_Byte  = tx_byte;
  assign bus.o_Grant_ID = last_grant;
  assign bus.o_Busy     = busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter driving a behavioural UART_TX (217 clocks per bit)
// whose serial line is decoded and checked against the bytes each scenario expects.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int CLKS_PER_BIT = 217;

  typedef struct packed {
    logic [7:0] tx_byte;
    logic [1:0] grant;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_line = 1'b1;
  logic model_busy = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [$];
  logic [7:0] ser_q [$];

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe both requesters for one cycle starting at a falling edge.
  task automatic apply_stimulus(input logic [1:0] dv, input logic [7:0] b1, input logic [7:0] b0);
    bus.i_Req_DV   = dv;
    bus.i_Req_Byte = {b1, b0};
    @(negedge clk);
    bus.i_Req_DV   = 2'b00;
  endtask

  task automatic expect_tx(input logic [7:0] b, input logic [1:0] g);
    exp_t e;
    e.tx_byte = b;
    e.grant   = g;
    exp_q.push_back(e);
    ser_q.push_back(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_tx_dv",   32'(bus.o_TX_DV),    32'h0);
    check_output("rst_tx_byte", 32'(bus.o_TX_Byte),  32'h00);
    check_output("rst_grant",   32'(bus.o_Grant_ID), 32'h1);
    check_output("rst_busy",    32'(bus.o_Busy),     32'h0);
    check_output("rst_full",    32'(bus.o_Req_Full), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || ser_q.size() != 0 || bus.o_Busy || model_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_drain_timeout"}, 32'(n >= 20000), 32'h0);
    check_output({name, "_line_idle"}, 32'(tx_line), 32'h1);
  endtask

  // Behavioural UART_TX: serialize on each start strobe, then one-cycle done pulse.
  initial begin
    logic [7:0] b;
    bus.i_TX_Done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_TX_DV) begin
        model_busy = 1'b1;
        b = bus.o_TX_Byte;
        tx_line = 1'b0;
        repeat (CLKS_PER_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          tx_line = b[i];
          repeat (CLKS_PER_BIT) @(negedge clk);
        end
        tx_line = 1'b1;
        repeat (CLKS_PER_BIT) @(negedge clk);
        bus.i_TX_Done = 1'b1;
        @(negedge clk);
        bus.i_TX_Done = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  // Start-strobe monitor: every o_TX_DV must match the next expected grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_TX_DV) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_tx_dv", 32'(bus.o_TX_Byte), 32'h100);
        end else begin
          e = exp_q.pop_front();
          check_output("tx_byte",  32'(bus.o_TX_Byte),  32'(e.tx_byte));
          check_output("grant_id", 32'(bus.o_Grant_ID), 32'(e.grant));
        end
      end
    end
  end

  // Serial decoder: sample mid-bit after each falling start edge.
  initial begin
    logic [7:0] rx;
    forever begin
      @(negedge tx_line);
      repeat (CLKS_PER_BIT / 2) @(posedge clk);
      check_output("ser_start", 32'(tx_line), 32'h0);
      for (int i = 0; i < 8; i++) begin
        repeat (CLKS_PER_BIT) @(posedge clk);
        rx[i] = tx_line;
      end
      repeat (CLKS_PER_BIT) @(posedge clk);
      check_output("ser_stop", 32'(tx_line), 32'h1);
      if (ser_q.size() == 0) begin
        check_output("unexpected_serial", 32'(rx), 32'h100);
      end else begin
        check_output("ser_byte", 32'(rx), 32'(ser_q.pop_front()));
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    int s1;
    int n;
    logic [1:0] dv;
    bus.i_Req_DV   = 2'b00;
    bus.i_Req_Byte = 16'h0000;
`ifdef UART_ARB_OVF_EN
    bus.i_Ovf_Clr  = 1'b0;
`endif
    @(negedge clk);
    do_reset();

    // Single request: strobe in cycle N, start strobe in N+2.
    repeat (5) @(negedge clk);
    expect_tx(8'h41, 2'd0);
    apply_stimulus(2'b01, 8'h00, 8'h41);
    check_output("single_full_n1", 32'(bus.o_Req_Full[0]), 32'h1);
    check_output("single_dv_n1",   32'(bus.o_TX_DV),        32'h0);
    @(negedge clk);
    check_output("single_dv_n2",    32'(bus.o_TX_DV),        32'h1);
    check_output("single_full_n2",  32'(bus.o_Req_Full[0]),  32'h0);
    check_output("single_busy_n2",  32'(bus.o_Busy),         32'h1);
    wait_drain("single");

    // Contention after reset: requester 0 first.
    do_reset();
    expect_tx(8'hA5, 2'd0);
    expect_tx(8'h3C, 2'd1);
    apply_stimulus(2'b11, 8'h3C, 8'hA5);
    wait_drain("contention");
    check_output("contention_last_grant", 32'(bus.o_Grant_ID), 32'h1);

    // Fairness: both refill as soon as their register empties.
    for (int i = 0; i < 3; i++) begin
      expect_tx(8'h10 + 8'(i), 2'd0);
      expect_tx(8'h20 + 8'(i), 2'd1);
    end
    s0 = 0;
    s1 = 0;
    n  = 0;
    while ((s0 < 3 || s1 < 3) && n < 20000) begin
      dv = 2'b00;
      if (s0 < 3 && !bus.o_Req_Full[0]) dv[0] = 1'b1;
      if (s1 < 3 && !bus.o_Req_Full[1]) dv[1] = 1'b1;
      bus.i_Req_DV   = dv;
      bus.i_Req_Byte = {8'h20 + 8'(s1), 8'h10 + 8'(s0)};
      if (dv[0]) s0++;
      if (dv[1]) s1++;
      @(negedge clk);
      bus.i_Req_DV = 2'b00;
      n++;
    end
    wait_drain("fairness");

    // Refill on the same edge the grant empties the register.
    do_reset();
    expect_tx(8'h55, 2'd0);
    expect_tx(8'h66, 2'd0);
    apply_stimulus(2'b01, 8'h00, 8'h55);
    apply_stimulus(2'b01, 8'h00, 8'h66);
    check_output("sameedge_dv",   32'(bus.o_TX_DV),        32'h1);
    check_output("sameedge_full", 32'(bus.o_Req_Full[0]),  32'h1);
    wait_drain("sameedge");

    // Drop while full: 8'h22 must never be sent.
    do_reset();
    expect_tx(8'h77, 2'd0);
    expect_tx(8'h11, 2'd1);
    apply_stimulus(2'b01, 8'h00, 8'h77);
    repeat (20) @(negedge clk);
    apply_stimulus(2'b10, 8'h11, 8'h00);
    apply_stimulus(2'b10, 8'h22, 8'h00);
    check_output("drop_full1", 32'(bus.o_Req_Full[1]), 32'h1);
`ifdef UART_ARB_OVF_EN
    check_output("ovf_set", 32'(bus.o_Overflow), 32'h2);
`endif
    wait_drain("drop");
`ifdef UART_ARB_OVF_EN
    check_output("ovf_sticky", 32'(bus.o_Overflow), 32'h2);
    bus.i_Ovf_Clr = 1'b1;
    @(negedge clk);
    bus.i_Ovf_Clr = 1'b0;
    check_output("ovf_cleared", 32'(bus.o_Overflow), 32'h0);
`endif

    // Reset during WAIT_DONE with a pending byte; later done pulse must be ignored.
    expect_tx(8'h5A, 2'd0);
    apply_stimulus(2'b01, 8'h00, 8'h5A);
    repeat (50) @(negedge clk);
    apply_stimulus(2'b01, 8'h00, 8'h99);
    check_output("midrst_pending", 32'(bus.o_Req_Full[0]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_busy",  32'(bus.o_Busy),     32'h0);
    check_output("midrst_full",  32'(bus.o_Req_Full), 32'h0);
    check_output("midrst_byte",  32'(bus.o_TX_Byte),  32'h00);
    check_output("midrst_grant", 32'(bus.o_Grant_ID), 32'h1);
    check_output("midrst_dv",    32'(bus.o_TX_DV),    32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_drain("midrst");
    repeat (20) @(negedge clk);
    check_output("midrst_idle_after_done", 32'(bus.o_Busy),     32'h0);
    check_output("midrst_full_after_done", 32'(bus.o_Req_Full), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
